// File: rtl/clarvi_data_mem_responder.sv
// Data-memory responder for the core's load/store port.
// Word-addressed 64-bit storage with byte-masked writes.
// Reads return in order after a fixed READ_LATENCY.
// Back-pressure (main_wait) is derived from the registered count of outstanding reads.
module clarvi_data_mem_responder #(
    parameter int DATA_ADDR_WIDTH = 14,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [61-DATA_ADDR_WIDTH-1:0]            address_high_bits,
    input  logic [DATA_ADDR_WIDTH-1:0]               main_address,
    input  logic [7:0]                               main_byte_enable,
    input  logic                                     main_read_enable,
    input  logic                                     main_write_enable,
    input  logic [63:0]                              main_write_data,
    output logic                                     main_wait,
    output logic [63:0]                              main_read_data,
    output logic                                     main_read_valid,
    output logic                                     main_read_error,
    output logic                                     main_write_error,
    output logic                                     protocol_error,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_count
);

    localparam int                CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int                DEPTH   = 1 << DATA_ADDR_WIDTH;
    localparam logic [CW-1:0]     MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0]     ONE_CNT = CW'(1);

    // Storage array; contents deliberately survive reset.
    logic [63:0] r_mem [0:DEPTH-1];

    // Response pipeline; the last stage drives the outputs.
    logic        r_pv [0:READ_LATENCY-1];
    logic        r_pe [0:READ_LATENCY-1];
    logic [63:0] r_pd [0:READ_LATENCY-1];

    logic [CW-1:0] r_count;
    logic          r_wr_err;
    logic          r_proto;

    logic        w_conflict;
    logic        w_in_range;
    logic        w_rd_acc;
    logic        w_wr_acc;
    logic [63:0] w_rd_word;

    // A simultaneous read and write is a protocol violation; neither access is performed.
    assign w_conflict = main_read_enable & main_write_enable;
    assign w_in_range = (address_high_bits == '0);
    assign w_rd_acc   = main_read_enable & ~main_write_enable & ~main_wait;
    assign w_wr_acc   = main_write_enable & ~main_read_enable & ~main_wait;

    // Out-of-range reads never touch the array and return zero.
    always_comb begin
        w_rd_word = 64'd0;
        if (w_in_range) begin
            w_rd_word = r_mem[main_address];
        end else begin
            w_rd_word = 64'd0;
        end
    end

    // Byte-masked write into the array on an accepted in-range write.
    always_ff @(posedge clock) begin
        if (w_wr_acc && w_in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (main_byte_enable[i]) begin
                    r_mem[main_address][8*i +: 8] <= main_write_data[8*i +: 8];
                end
            end
        end
    end

    // Shift read responses through the pipeline; data stages load only with a valid, so the output holds between responses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pe[i] <= 1'b0;
                r_pd[i] <= 64'd0;
            end
        end else begin
            r_pv[0] <= w_rd_acc;
            r_pe[0] <= w_rd_acc & ~w_in_range;
            if (w_rd_acc) begin
                r_pd[0] <= w_rd_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pv[i-1] & r_pe[i-1];
                if (r_pv[i-1]) begin
                    r_pd[i] <= r_pd[i-1];
                end
            end
        end
    end

    // Outstanding-read counter: up on acceptance, down on the edge that sees a valid response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_rd_acc, main_read_valid})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle write-error pulse and the sticky protocol-error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_err <= 1'b0;
            r_proto  <= 1'b0;
        end else begin
            r_wr_err <= w_wr_acc & ~w_in_range;
            if (w_conflict) begin
                r_proto <= 1'b1;
            end
        end
    end

    assign main_wait         = (r_count == MAX_CNT);
    assign main_read_valid   = r_pv[READ_LATENCY-1];
    assign main_read_error   = r_pe[READ_LATENCY-1];
    assign main_read_data    = r_pd[READ_LATENCY-1];
    assign main_write_error  = r_wr_err;
    assign protocol_error    = r_proto;
    assign outstanding_count = r_count;

endmodule

// File: doc/clarvi_data_mem_responder.md
Name: clarvi_data_mem_responder

Overview:
Memory-side responder for the core's data memory port: it serves the load/store requests the core's address-generation stage issues. It accepts word-addressed 64-bit requests with per-byte enables, performs byte-masked writes into a local storage array, and returns full 64-bit read words after a fixed, parameterised latency. It tracks outstanding reads and applies back-pressure (main_wait), which the core uses as its memory-pending stall. It also flags out-of-range addresses and protocol violations.

Parameters:
DATA_ADDR_WIDTH, 14, word-address width; the array holds 2^DATA_ADDR_WIDTH 64-bit words
READ_LATENCY, 2, cycles from the request-acceptance edge to main_read_valid; legal range 1..4
MAX_OUTSTANDING, 2, maximum accepted reads not yet answered; legal range 1..READ_LATENCY

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
address_high_bits  in  61-DATA_ADDR_WIDTH  address bits above the array range; must be zero
main_address  in  DATA_ADDR_WIDTH  word address
main_byte_enable  in  8  write byte mask; bit i selects bits 8i+7..8i; ignored on reads
main_read_enable  in  1  read request
main_write_enable  in  1  write request
main_write_data  in  64  write data, already shifted into byte lanes
main_wait  out  1  back-pressure; no request is accepted while high
main_read_data  out  64  read response word
main_read_valid  out  1  one-cycle pulse per read response
main_read_error  out  1  qualifies main_read_valid: the address was out of range
main_write_error  out  1  one-cycle pulse: a write was dropped for an out-of-range address
protocol_error  out  1  sticky: read and write were requested in the same cycle
outstanding_count  out  $clog2(MAX_OUTSTANDING+1)  accepted reads not yet answered

Behaviour:
- Reset values: main_wait=0, main_read_data=0, main_read_valid=0, main_read_error=0, main_write_error=0, protocol_error=0, outstanding_count=0.
- Reset clears the response pipeline and the outstanding count. In-flight reads are discarded and produce no main_read_valid after reset. Array contents are not reset.
- main_wait = (outstanding_count == MAX_OUTSTANDING). It is driven combinationally from the registered count and stalls both reads and writes.
- Acceptance: a read or write is accepted on the edge where its enable=1 and main_wait=0. Requests seen while main_wait=1 are ignored, and the requester must hold them.
- Simultaneous read and write enables: neither access is performed and protocol_error sets on that edge. It stays set until reset.
- Accepted write with address_high_bits==0: at the acceptance edge, each byte i with main_byte_enable[i]=1 takes main_write_data byte i; other bytes are unchanged. An all-zero mask is a legal no-op.
- Accepted write with address_high_bits!=0: the array is untouched and main_write_error=1 for exactly the following cycle.
- Accepted read: the array is read at the acceptance edge. The word is carried through a READ_LATENCY-deep valid/data/error pipeline. main_read_valid is asserted exactly READ_LATENCY cycles after acceptance, for one cycle.
- Read with address_high_bits!=0: the array is not accessed; the response returns with data=0 and main_read_error=1, at the same latency.
- Ordering: a write accepted on edge N is visible to a read accepted on edge N+1 or later. Responses return in acceptance order, and back-to-back reads give back-to-back valids.
- main_read_data holds its last value between valids. main_read_error is 0 whenever main_read_valid is 0.
- outstanding_count: +1 on an accepted read, -1 when main_read_valid is asserted, unchanged when both happen on the same edge. It never exceeds MAX_OUTSTANDING or goes below 0.
- A retiring response does not release main_wait in the same cycle, because main_wait comes from the registered count.

Test Plan:
- Reset, then write 0x1122334455667788 to addr 5 with be=0xFF; read addr 5 -> main_read_valid exactly 2 cycles after acceptance, data 0x1122334455667788, error=0, outstanding_count returns to 0.
- Write addr 5 with be=0x0C and data 0x00000000AABB0000; read -> 0x11223344AABB7788. Write with be=0x00 -> a following read is unchanged.
- Back-to-back reads of addr 1,2,3 with MAX_OUTSTANDING=2 -> main_wait high after the 2nd acceptance; the 3rd read is held and accepted one cycle after the first valid; three valids return in order 1,2,3.
- address_high_bits=1: read -> valid after 2 cycles with data 0 and main_read_error=1; write -> main_write_error pulse the next cycle and the array is unchanged.
- Read and write asserted together -> no access, no valid, protocol_error stays 1 until reset.
- Assert reset 1 cycle after a read acceptance -> no main_read_valid ever appears, outstanding_count=0, and earlier-written data is still readable after reset.
